card_dealer: RTL and testbench

CARD_DEALER -- requirements
Module: card_dealer

---
 rtl/card_pkg.sv | 23 ++
 rtl/card_dealer_if.sv | 21 ++
 rtl/card_lfsr.sv | 23 ++
 rtl/card_dealer.sv | 115 +++++++++++
 tb/tb_card_dealer.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/card_pkg.sv
// Shared constants, FSM state type and rank helper for the card dealer.
package card_pkg;

    localparam int          DECK_SIZE    = 52;
    localparam int          NUM_RANKS    = 13;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_SHUFFLE = 2'd1,
        ST_READY   = 2'd2,
        ST_EMPTY   = 2'd3
    } state_e;

    // Rank written to slot i during fill: 1..13 repeating.
    function automatic logic [3:0] fill_rank(input logic [5:0] i);
        logic [5:0] r;
        r = i % 6'(NUM_RANKS);
        return r[3:0] + 4'd1;
    endfunction

endpackage

// File: rtl/card_dealer_if.sv
// Controller <-> dealer bus: deal/shuffle requests in, card and status out.
interface card_dealer_if;
    logic       pip;
    logic       shuffle;
    logic [3:0] number;
    logic       valid;
    logic       busy;
    logic       empty;
    logic [5:0] cards_left;
    logic       miss;

    modport master (
        output pip, shuffle,
        input  number, valid, busy, empty, cards_left, miss
    );

    modport slave (
        input  pip, shuffle,
        output number, valid, busy, empty, cards_left, miss
    );
endinterface

// File: rtl/card_lfsr.sv
// Free-running 16-bit Galois LFSR, reloaded only by reset.
module card_lfsr
    import card_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    assign q_d = q_q[0] ? ({1'b0, q_q[15:1]} ^ LFSR_TAPS) : {1'b0, q_q[15:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= seed;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/card_dealer.sv
// Card dealer: fills a 52-card deck, Fisher-Yates shuffles it with an LFSR,
// then deals one card per pip.
module card_dealer #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          DECK_SIZE = 52
) (
    input  logic         clk,
    input  logic         rst,
    card_dealer_if.slave bus
);
    import card_pkg::*;

    localparam logic [5:0] LAST = 6'(DECK_SIZE - 1);

    state_e      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [5:0]  ptr_q, ptr_d;
    logic [3:0]  number_q, number_d;
    logic        valid_q, valid_d;
    logic        miss_q, miss_d;
    logic [3:0]  deck_q [DECK_SIZE];

    logic [15:0] lfsr_q;
    logic [5:0]  j;
    logic        swap;
    logic        lfsr_unused;

    card_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (SEED),
        .q    (lfsr_q)
    );

    assign j           = lfsr_q[5:0];
    assign lfsr_unused = ^lfsr_q[15:6];
    // Out-of-range candidates are rejected and retried on the next LFSR value.
    assign swap        = (state_q == ST_SHUFFLE) && (j <= idx_q);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        number_d = number_q;
        valid_d  = 1'b0;
        miss_d   = 1'b0;
        if (bus.shuffle) begin
            state_d  = ST_FILL;
            idx_d    = '0;
            ptr_d    = '0;
            number_d = '0;
            miss_d   = bus.pip;
        end else begin
            case (state_q)
                ST_FILL: begin
                    miss_d = bus.pip;
                    if (idx_q == LAST) state_d = ST_SHUFFLE;
                    else               idx_d   = idx_q + 6'd1;
                end
                ST_SHUFFLE: begin
                    miss_d = bus.pip;
                    if (swap) begin
                        if (idx_q == 6'd1) state_d = ST_READY;
                        else               idx_d   = idx_q - 6'd1;
                    end
                end
                ST_READY: begin
                    if (bus.pip) begin
                        number_d = deck_q[ptr_q];
                        valid_d  = 1'b1;
                        ptr_d    = ptr_q + 6'd1;
                        if (ptr_q == LAST) state_d = ST_EMPTY;
                    end
                end
                default: miss_d = bus.pip;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FILL;
            idx_q    <= '0;
            ptr_q    <= '0;
            number_q <= '0;
            valid_q  <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            number_q <= number_d;
            valid_q  <= valid_d;
            miss_q   <= miss_d;
        end
    end

    // Deck is not reset: FILL rewrites every slot before it is ever read.
    always_ff @(posedge clk) begin
        if (state_q == ST_FILL) begin
            deck_q[idx_q] <= fill_rank(idx_q);
        end else if (swap) begin
            deck_q[idx_q] <= deck_q[j];
            deck_q[j]     <= deck_q[idx_q];
        end
    end

    assign bus.number     = number_q;
    assign bus.valid      = valid_q;
    assign bus.miss       = miss_q;
    assign bus.busy       = (state_q == ST_FILL) || (state_q == ST_SHUFFLE);
    assign bus.empty      = (state_q == ST_EMPTY);
    assign bus.cards_left = 6'(DECK_SIZE) - ptr_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: reset, fill/shuffle timing, full deals, misses, reshuffle, replay.
module tb_card_dealer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    card_dealer_if bus ();

    card_dealer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_run  = 0;
    int n_fail = 0;
    int cur  [52];
    int seq1 [52];
    int seq2 [52];
    int hist [14];

    task automatic chk(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        chk("ready_timeout", int'(n < 5000), 1);
    endtask

    // One deal with 3-cycle spacing; checks latency and hold of number.
    task automatic deal_one(input int left_exp, output int card);
        bus.pip = 1'b1;
        tick();
        bus.pip = 1'b0;
        chk("deal_valid", bus.valid, 1);
        chk("deal_miss", bus.miss, 0);
        card = int'(bus.number);
        chk("deal_left", bus.cards_left, left_exp);
        chk("deal_empty", bus.empty, int'(left_exp == 0));
        tick();
        chk("valid_pulse", bus.valid, 0);
        chk("number_hold", bus.number, card);
        tick();
    endtask

    task automatic deal_deck();
        int c;
        for (int r = 0; r < 14; r++) hist[r] = 0;
        for (int k = 0; k < 52; k++) begin
            deal_one(51 - k, c);
            cur[k] = c;
            if (c >= 1 && c <= 13) hist[c]++;
        end
        for (int r = 1; r <= 13; r++) chk($sformatf("rank%0d_count", r), hist[r], 4);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c, diff, held;
        bus.pip     = 1'b0;
        bus.shuffle = 1'b0;
        #2 rst = 1'b1;
        repeat (3) tick();

        chk("rst_number", bus.number, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_miss", bus.miss, 0);
        chk("rst_busy", bus.busy, 1);
        chk("rst_empty", bus.empty, 0);
        chk("rst_left", bus.cards_left, 52);

        rst = 1'b0;
        // pip while filling is dropped
        bus.pip = 1'b1;
        tick();
        bus.pip = 1'b0;
        chk("busy_pip_miss", bus.miss, 1);
        chk("busy_pip_valid", bus.valid, 0);
        chk("busy_pip_left", bus.cards_left, 52);
        tick();
        chk("miss_pulse", bus.miss, 0);
        wait_ready(n);
        chk("busy_min_103", int'(n + 2 >= 103), 1);
        chk("ready_left", bus.cards_left, 52);
        chk("ready_empty", bus.empty, 0);
        chk("ready_number", bus.number, 0);

        deal_deck();
        seq1 = cur;
        held = seq1[51];

        // 53rd pip in EMPTY
        bus.pip = 1'b1;
        tick();
        bus.pip = 1'b0;
        chk("empty_miss", bus.miss, 1);
        chk("empty_valid", bus.valid, 0);
        chk("empty_number", bus.number, held);
        chk("empty_left", bus.cards_left, 0);
        chk("empty_flag", bus.empty, 1);

        bus.shuffle = 1'b1;
        tick();
        bus.shuffle = 1'b0;
        chk("shuf_busy", bus.busy, 1);
        chk("shuf_number", bus.number, 0);
        chk("shuf_left", bus.cards_left, 52);
        wait_ready(n);
        for (int k = 0; k < 5; k++) deal_one(51 - k, c);

        // pip and shuffle together: shuffle wins
        bus.pip     = 1'b1;
        bus.shuffle = 1'b1;
        tick();
        bus.pip     = 1'b0;
        bus.shuffle = 1'b0;
        chk("both_miss", bus.miss, 1);
        chk("both_valid", bus.valid, 0);
        chk("both_number", bus.number, 0);
        chk("both_busy", bus.busy, 1);
        wait_ready(n);
        chk("reshuf_left", bus.cards_left, 52);
        deal_deck();
        seq2 = cur;
        diff = 0;
        for (int k = 0; k < 52; k++) if (seq2[k] != seq1[k]) diff++;
        chk("new_order_differs", int'(diff > 0), 1);

        // reset in the middle of shuffling, then replay
        bus.shuffle = 1'b1;
        tick();
        bus.shuffle = 1'b0;
        repeat (70) tick();
        chk("mid_shuffle_busy", bus.busy, 1);
        rst = 1'b1;
        tick();
        tick();
        chk("rst2_left", bus.cards_left, 52);
        rst = 1'b0;
        wait_ready(n);
        deal_deck();
        diff = 0;
        for (int k = 0; k < 52; k++) if (cur[k] != seq1[k]) diff++;
        chk("rst_replay_mismatches", diff, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
